demodulate: RTL
===============

Name: demodulate

Overview:
- FM discriminator front-end that acts as the initiator for the quadrature-arctan/divider responder.
- Pops complex I/Q samples from an input FIFO and forms the conjugate product of the current sample with the previous one.
- Hands the product (x, y) to the qarctan responder over its valid/ready/done handshake and waits for the angle.
- Scales the angle by the demodulation gain and pushes the result into an output FIFO.

Parameters:
- DATA_WIDTH, 32, width of I/Q samples, x/y, angle and output.
- BITS, 10, fixed-point fraction bits used by DEQUANTIZE.
- GAIN, 758, quantized FM demod gain, signed.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- real_in  in  DATA_WIDTH  I sample, FIFO head
- imag_in  in  DATA_WIDTH  Q sample, FIFO head
- in_empty  in  1  input FIFO empty
- in_rd_en  out  1  input FIFO pop
- x  out  DATA_WIDTH  real part of conjugate product, to qarctan
- y  out  DATA_WIDTH  imaginary part of conjugate product, to qarctan
- demod_data_valid  out  1  start request to qarctan
- divider_ready  in  1  qarctan idle / able to accept
- qarctan_data  in  DATA_WIDTH  angle from qarctan, valid with qarctan_done
- qarctan_done  in  1  angle valid, single-cycle
- demod_out  out  DATA_WIDTH  scaled demodulated sample
- out_full  in  1  output FIFO full
- out_wr_en  out  1  output FIFO push

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - state = READ.
  - Output-side: x, y, demod_out = 0; in_rd_en, demod_data_valid, out_wr_en = 0.
  - Internal: prev_r, prev_i, cur_r, cur_i, angle = 0.
- DEQUANTIZE(v): signed divide by 2^BITS, truncating toward zero (negative v gives -((-v) >> BITS)).
- All products are computed as full 2*DATA_WIDTH signed values; the result keeps the low DATA_WIDTH bits after DEQUANTIZE.
- READ:
  - If !in_empty: in_rd_en = 1 (combinational, one cycle), latch cur_r = real_in and cur_i = imag_in, go to CALC.
  - Otherwise stay in READ.
- CALC (1 cycle):
  - x <= DEQUANTIZE(cur_r*prev_r + cur_i*prev_i).
  - y <= DEQUANTIZE(cur_i*prev_r - cur_r*prev_i).
  - prev <= cur.
  - Go to ISSUE.
- ISSUE:
  - demod_data_valid = divider_ready, combinational; it is never asserted while divider_ready = 0.
  - When divider_ready = 1, go to WAIT.
- WAIT:
  - On qarctan_done = 1: angle <= qarctan_data, go to WRITE.
  - x and y are held stable from CALC exit until WAIT exits, because the responder re-reads them when it completes.
- WRITE:
  - demod_out = DEQUANTIZE(GAIN * angle), held stable.
  - If !out_full: out_wr_en = 1 for one cycle, go to READ.
- Latency:
  - Minimum 4 cycles plus the responder's divide time, from pop to push.
  - One sample is in flight at a time; no overlap.
- Boundary conditions:
  - First sample after reset: prev = 0, so x = y = 0 (responder zero case).
  - qarctan_done arriving in any state other than WAIT is ignored.
  - out_full held: stay in WRITE with no pop and demod_out held.
  - in_empty held: stay in READ with all strobes 0.
  - Reset mid-operation: immediate return to reset values; prev history is lost; any in-flight angle is discarded.
  - Arithmetic wrap: low-bit truncation only, no saturation.

Test Plan:
- Reset, then push (1024, 0) with a bench qarctan returning 1608 for x = y = 0 -> x = 0, y = 0, one demod_data_valid pulse, out_wr_en once with demod_out = 1190.
- Follow with (1024, 0), model returns 0 -> x = 1024, y = 0, demod_out = 0.
- Then push (0, 1024) -> x = 0, y = 1024; model returns 1608 -> demod_out = 1190. Then push (1024, 0) -> y = -1024; model returns -804 -> demod_out = -595 (truncation toward zero).
- Hold divider_ready = 0 for 6 cycles in ISSUE -> demod_data_valid stays 0 and x/y stay stable; raise it -> exactly one valid cycle.
- Hold out_full = 1 for 5 cycles in WRITE -> out_wr_en = 0, in_rd_en = 0, demod_out constant; release -> single push, next pop follows.
- Assert reset during WAIT, then send a spurious qarctan_done -> outputs return to 0, no push occurs, and the next sample sees prev = 0 (x = y = 0).

Source files
------------

// File: rtl/demodulate.sv
// ---------------------------------------------------------------------------
// demodulate
// FM discriminator front-end. Pops one complex I/Q sample at a time from an
// input FIFO, forms the conjugate product with the previous sample, hands the
// product (x, y) to the qarctan responder, waits for the angle, scales it by
// the demodulation gain and pushes the result into an output FIFO.
// Only one sample is in flight at a time.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   real_in, imag_in  I/Q sample at the head of the input FIFO
//   in_empty          input FIFO empty
//   in_rd_en          input FIFO pop (combinational, one cycle)
//   x, y              conjugate product to qarctan, held until the angle returns
//   demod_data_valid  start request to qarctan (only while divider_ready = 1)
//   divider_ready     qarctan idle / able to accept
//   qarctan_data      angle from qarctan, valid with qarctan_done
//   qarctan_done      single-cycle angle valid
//   demod_out         scaled demodulated sample
//   out_full          output FIFO full
//   out_wr_en         output FIFO push (combinational, one cycle)
// ---------------------------------------------------------------------------
module demodulate #(
    parameter int DATA_WIDTH = 32,
    parameter int BITS       = 10,
    parameter int GAIN       = 758
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] real_in,
    input  logic signed [DATA_WIDTH-1:0] imag_in,
    input  logic                         in_empty,
    output logic                         in_rd_en,
    output logic signed [DATA_WIDTH-1:0] x,
    output logic signed [DATA_WIDTH-1:0] y,
    output logic                         demod_data_valid,
    input  logic                         divider_ready,
    input  logic signed [DATA_WIDTH-1:0] qarctan_data,
    input  logic                         qarctan_done,
    output logic signed [DATA_WIDTH-1:0] demod_out,
    input  logic                         out_full,
    output logic                         out_wr_en
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam logic signed [PW-1:0] GAIN_W = PW'(GAIN);

    typedef enum logic [2:0] {
        READ,
        CALC,
        ISSUE,
        WAIT,
        WRITE
    } state_t;

    state_t                       state_q;
    logic signed [DATA_WIDTH-1:0] curR_q;
    logic signed [DATA_WIDTH-1:0] curI_q;
    logic signed [DATA_WIDTH-1:0] prevR_q;
    logic signed [DATA_WIDTH-1:0] prevI_q;
    logic signed [DATA_WIDTH-1:0] angle_q;
    logic signed [DATA_WIDTH-1:0] x_q;
    logic signed [DATA_WIDTH-1:0] y_q;
    logic signed [DATA_WIDTH-1:0] x_d;
    logic signed [DATA_WIDTH-1:0] y_d;

    // Signed divide by 2^BITS rounding toward zero, keeping the low
    // DATA_WIDTH bits of the full-width quotient (wraps, never saturates).
    function automatic logic signed [DATA_WIDTH-1:0] dequantize(
        input logic signed [PW-1:0] v
    );
        logic signed [PW-1:0] q;
        if (v < 0) begin
            q = -((-v) >>> BITS);
        end else begin
            q = v >>> BITS;
        end
        return DATA_WIDTH'(q);
    endfunction

    // Conjugate product cur * conj(prev) at full double width.
    always_comb begin
        logic signed [PW-1:0] cr;
        logic signed [PW-1:0] ci;
        logic signed [PW-1:0] pr;
        logic signed [PW-1:0] pi;
        cr  = curR_q;
        ci  = curI_q;
        pr  = prevR_q;
        pi  = prevI_q;
        x_d = dequantize(cr * pr + ci * pi);
        y_d = dequantize(ci * pr - cr * pi);
    end

    // Scaled angle; depends only on the stored angle, so it stays constant
    // for as long as the FSM waits in WRITE.
    always_comb begin
        logic signed [PW-1:0] aw;
        aw        = angle_q;
        demod_out = dequantize(GAIN_W * aw);
    end

    // Handshake strobes are combinational decodes of the state; they are
    // forced low while reset is held.
    assign in_rd_en         = !reset && (state_q == READ)  && !in_empty;
    assign demod_data_valid = !reset && (state_q == ISSUE) && divider_ready;
    assign out_wr_en        = !reset && (state_q == WRITE) && !out_full;
    assign x                = x_q;
    assign y                = y_q;

    // Sample-at-a-time sequencer. x/y only change in CALC, so they stay
    // stable through ISSUE and WAIT while the responder may re-read them.
    // A qarctan_done outside WAIT has no effect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= READ;
            curR_q  <= '0;
            curI_q  <= '0;
            prevR_q <= '0;
            prevI_q <= '0;
            angle_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            case (state_q)
                READ: begin
                    if (!in_empty) begin
                        curR_q  <= real_in;
                        curI_q  <= imag_in;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    x_q     <= x_d;
                    y_q     <= y_d;
                    prevR_q <= curR_q;
                    prevI_q <= curI_q;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    if (divider_ready) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (qarctan_done) begin
                        angle_q <= qarctan_data;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    if (!out_full) begin
                        state_q <= READ;
                    end
                end
                default: state_q <= READ;
            endcase
        end
    end

endmodule
